mesm6_membus: RTL and testbench

Single-port memory arbiter between the mesm6 core and the unified 48-bit main memory. It merges the core's instruction-fetch bus (ibus) and data bus (dbus) onto one memory request/acknowledge port and serialises simultaneous requests. Both core-side completions are presented in the same cycle, which the core's stall logic requires. It sits directly below the core and directly above the memory model or memory controller.

---
 rtl/mesm6_membus.sv | 155 +++++++++++++++
 tb/tb_mesm6_membus.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesm6_membus.sv
// mesm6_membus: merges the core ibus/dbus onto one memory port.
// Data before fetch; both dones are presented in one common cycle.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ibus_fetch/addr/input/done instruction-fetch side of the core
//   dbus_read/write/addr/output/input/done data side of the core
//   mem_req/we/addr/wdata/rdata/ack  single memory port
module mesm6_membus (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_fetch,
  input  logic [14:0] ibus_addr,
  output logic [47:0] ibus_input,
  output logic        ibus_done,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [14:0] dbus_addr,
  input  logic [47:0] dbus_output,
  output logic [47:0] dbus_input,
  output logic        dbus_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [47:0] mem_wdata,
  input  logic [47:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        pend_d_q, pend_d_d;
  logic        pend_i_q, pend_i_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [47:0] wdata_q, wdata_d;
  logic [47:0] iin_q, iin_d;
  logic [47:0] din_q, din_d;
  logic        idone_q, idone_d;
  logic        ddone_q, ddone_d;

  // An ack only counts while a request is actually outstanding.
  logic acked;
  assign acked = mem_ack & req_q;

  always_comb begin
    state_d  = state_q;
    pend_d_d = pend_d_q;
    pend_i_d = pend_i_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    iin_d    = iin_q;
    din_d    = din_q;
    idone_d  = 1'b0;
    ddone_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dbus_read | dbus_write) begin
          state_d  = DACC;
          pend_d_d = 1'b1;
          pend_i_d = ibus_fetch;
          req_d    = 1'b1;
          we_d     = dbus_write;
          addr_d   = dbus_addr;
          wdata_d  = dbus_output;
        end else if (ibus_fetch) begin
          state_d  = IACC;
          pend_i_d = 1'b1;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = ibus_addr;
        end
      end
      DACC: begin
        if (acked) begin
          req_d = 1'b0;
          if (!we_q) din_d = mem_rdata;
          if (pend_i_q) begin
            state_d = IACC;
          end else begin
            state_d = DONE;
            ddone_d = 1'b1;
          end
        end
      end
      IACC: begin
        // Entered from DACC with req low: relaunch
        // after a one-cycle gap as a fetch.
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = ibus_addr;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          iin_d   = mem_rdata;
          state_d = DONE;
          idone_d = 1'b1;
          ddone_d = pend_d_q;
        end
      end
      DONE: begin
        pend_d_d = 1'b0;
        pend_i_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pend_d_q <= 1'b0;
      pend_i_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      iin_q    <= '0;
      din_q    <= '0;
      idone_q  <= 1'b0;
      ddone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_d_q <= pend_d_d;
      pend_i_q <= pend_i_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      iin_q    <= iin_d;
      din_q    <= din_d;
      idone_q  <= idone_d;
      ddone_q  <= ddone_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign ibus_input = iin_q;
  assign dbus_input = din_q;
  assign ibus_done  = idone_q;
  assign dbus_done  = ddone_q;

endmodule

// File: tb/tb_mesm6_membus.sv
// Bench for mesm6_membus: transaction table plus
// memory responder and done scoreboards.
module tb_mesm6_membus;

  logic        clk;
  logic        reset;
  logic        ibus_fetch;
  logic [14:0] ibus_addr;
  logic [47:0] ibus_input;
  logic        ibus_done;
  logic        dbus_read;
  logic        dbus_write;
  logic [14:0] dbus_addr;
  logic [47:0] dbus_output;
  logic [47:0] dbus_input;
  logic        dbus_done;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [47:0] mem_wdata;
  logic [47:0] mem_rdata;
  logic        mem_ack;

  mesm6_membus dut (
    .clk         (clk),
    .reset       (reset),
    .ibus_fetch  (ibus_fetch),
    .ibus_addr   (ibus_addr),
    .ibus_input  (ibus_input),
    .ibus_done   (ibus_done),
    .dbus_read   (dbus_read),
    .dbus_write  (dbus_write),
    .dbus_addr   (dbus_addr),
    .dbus_output (dbus_output),
    .dbus_input  (dbus_input),
    .dbus_done   (dbus_done),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic        fe;
    logic [14:0] da;
    logic [14:0] ia;
    logic [47:0] wd;
    int          dly;
    bit          b2b;
  } txn_t;

  typedef struct {
    logic [14:0] a;
    logic        we;
    logic [47:0] wd;
  } acc_t;

  typedef struct {
    logic        ib;
    logic        db;
    logic [47:0] iv;
    logic [47:0] dv;
  } don_t;

  acc_t mq[$];
  don_t dq[$];

  int n_cmp = 0;
  int n_err = 0;

  int          mem_dly = 1;
  bit          mem_hold = 0;
  bit          stray = 0;
  logic [47:0] exp_ibin = '0;
  logic [47:0] exp_dbin = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] memf(input logic [14:0] a);
    if (a == 15'o1234) return 48'h0123_4567_89AB;
    return {a, ~a, 18'h2A5A5 ^ {3'b0, a}};
  endfunction

  // Memory responder: acks after mem_dly cycles, checks each
  // access against the expected-access queue and checks that
  // the request fields stay stable while mem_req is high.
  initial begin
    int          cnt;
    logic [63:0] snap;
    cnt = 0;
    snap = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (stray) begin
        mem_ack = 1'b1;
        mem_rdata = 48'hDEAD_BEEF_0BAD;
        stray = 0;
      end else if (mem_req === 1'b1) begin
        if (cnt == 0)
          snap = {mem_addr, mem_we, mem_wdata};
        else
          chk("mem_stable", {mem_addr, mem_we, mem_wdata}, snap);
        if (!mem_hold && cnt == mem_dly) begin
          mem_ack = 1'b1;
          mem_rdata = memf(mem_addr);
          if (mq.size() == 0) begin
            chk("unexpected_access", {49'h0, mem_addr}, 64'h7FFF_FFFF);
          end else begin
            acc_t e;
            e = mq.pop_front();
            chk("mem_addr", {49'h0, mem_addr}, {49'h0, e.a});
            chk("mem_we", {63'h0, mem_we}, {63'h0, e.we});
            if (e.we)
              chk("mem_wdata", {16'h0, mem_wdata}, {16'h0, e.wd});
          end
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Done monitor: pops the expected completion on each pulse.
  initial begin
    bit prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (prev)
        chk("done_width", {62'h0, ibus_done, dbus_done}, 64'h0);
      prev = 0;
      if (ibus_done === 1'b1 || dbus_done === 1'b1) begin
        prev = 1;
        if (dq.size() == 0) begin
          chk("unexpected_done", {62'h0, ibus_done, dbus_done}, 64'h0);
        end else begin
          don_t e;
          e = dq.pop_front();
          chk("ibus_done", {63'h0, ibus_done}, {63'h0, e.ib});
          chk("dbus_done", {63'h0, dbus_done}, {63'h0, e.db});
          chk("ibus_input", {16'h0, ibus_input}, {16'h0, e.iv});
          chk("dbus_input", {16'h0, dbus_input}, {16'h0, e.dv});
        end
      end
    end
  end

  task automatic idle_inputs();
    ibus_fetch = 1'b0;
    dbus_read = 1'b0;
    dbus_write = 1'b0;
  endtask

  // Called just after a rising edge; returns just after one.
  task automatic run(input txn_t t);
    int c;
    int lat;
    ibus_fetch = t.fe;
    ibus_addr = t.ia;
    dbus_read = t.rd;
    dbus_write = t.wr;
    dbus_addr = t.da;
    dbus_output = t.wd;
    mem_dly = t.dly;
    if (t.rd | t.wr) begin
      mq.push_back('{a: t.da, we: t.wr, wd: t.wd});
      if (!t.wr) exp_dbin = memf(t.da);
    end
    if (t.fe) begin
      mq.push_back('{a: t.ia, we: 1'b0, wd: 48'h0});
      exp_ibin = memf(t.ia);
    end
    dq.push_back('{ib: t.fe, db: t.rd | t.wr,
                   iv: exp_ibin, dv: exp_dbin});
    lat = ((t.rd | t.wr) && t.fe) ? 4 + 2 * t.dly : 2 + t.dly;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ibus_done === 1'b1 || dbus_done === 1'b1) break;
    end
    chk("latency", 64'(c), 64'(lat));
    @(posedge clk);
    #1;
    if (!t.b2b) begin
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  txn_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 15'o1234, 15'o0,
               48'h0, 2, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 15'o77, 15'o0,
               48'hFFFF_0000_FFFF, 1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 15'o10, 15'o20,
               48'h0, 1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 15'o0, 15'd5,
               48'h0, 1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 15'o0, 15'd6,
               48'h0, 3, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 15'd3, 15'o0,
               48'h000A_BCDE_F012, 1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 15'o777, 15'o0,
               48'h0, 4, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 15'o100, 15'o200,
               48'h1357_9BDF_2468, 2, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 15'o0, 15'o7777,
               48'h0, 1, 1'b0};

    reset = 1'b1;
    idle_inputs();
    ibus_addr = '0;
    dbus_addr = '0;
    dbus_output = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_we", {62'h0, mem_req, mem_we}, 64'h0);
    chk("rst_addr", {49'h0, mem_addr}, 64'h0);
    chk("rst_wdata", {16'h0, mem_wdata}, 64'h0);
    chk("rst_ibin", {16'h0, ibus_input}, 64'h0);
    chk("rst_dbin", {16'h0, dbus_input}, 64'h0);
    chk("rst_done", {62'h0, ibus_done, dbus_done}, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) run(tbl[i]);

    // Reset while a data read waits for its ack; late ack after.
    mem_hold = 1;
    dbus_read = 1'b1;
    dbus_addr = 15'o55;
    begin
      int c;
      for (c = 0; c < 10; c++) begin
        @(negedge clk);
        if (mem_req === 1'b1) break;
      end
      chk("mid_req_up", {63'h0, mem_req}, 64'h1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    dbus_read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    stray = 1;
    exp_dbin = '0;
    exp_ibin = '0;
    @(negedge clk);
    chk("mid_req_drop", {63'h0, mem_req}, 64'h0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_req_low", {63'h0, mem_req}, 64'h0);
      chk("mid_dbin", {16'h0, dbus_input}, {16'h0, exp_dbin});
      chk("mid_nodone", {62'h0, ibus_done, dbus_done}, 64'h0);
    end
    mem_hold = 0;
    @(posedge clk);
    #1;

    // Normal read after the aborted access still works.
    run('{1'b1, 1'b0, 1'b0, 15'o4321, 15'o0, 48'h0, 1, 1'b0});

    chk("acc_queue_empty", 64'(mq.size()), 64'h0);
    chk("done_queue_empty", 64'(dq.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
